// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module : mdu_pkg
//  Brief  : Shared MDU op codes, default latencies and controller state type.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
//  Module : mdu_ctrl
//  Brief  : Multi-cycle MULT/DIV controller owning the HI/LO registers.
//           Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU are no-ops.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_mdop,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_isMd,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        isStall_md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic [63:0]      prod_s, prod_u;

  assign prod_s = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
  assign prod_u = {32'b0, E_rs} * {32'b0, E_rt};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    if (state_q == MD_IDLE) begin
      if (E_start) begin
        case (E_mdop)
          MD_MULT: begin
            {phi_d, plo_d} = prod_s;
            cnt_d          = CNT_W'(MULT_CYCLES);
            state_d        = MD_BUSY;
          end
          MD_MULTU: begin
            {phi_d, plo_d} = prod_u;
            cnt_d          = CNT_W'(MULT_CYCLES);
            state_d        = MD_BUSY;
          end
`ifdef MDU_DIV_EN
          // Zero divisor and the single signed overflow case get fixed results.
          MD_DIV: begin
            if (E_rt == 32'd0) begin
              phi_d = E_rs;
              plo_d = 32'hFFFF_FFFF;
            end else if (E_rs == 32'h8000_0000 && E_rt == 32'hFFFF_FFFF) begin
              phi_d = 32'd0;
              plo_d = 32'h8000_0000;
            end else begin
              plo_d = $signed(E_rs) / $signed(E_rt);
              phi_d = $signed(E_rs) % $signed(E_rt);
            end
            cnt_d   = CNT_W'(DIV_CYCLES);
            state_d = MD_BUSY;
          end
          MD_DIVU: begin
            if (E_rt == 32'd0) begin
              phi_d = E_rs;
              plo_d = 32'hFFFF_FFFF;
            end else begin
              plo_d = E_rs / E_rt;
              phi_d = E_rs % E_rt;
            end
            cnt_d   = CNT_W'(DIV_CYCLES);
            state_d = MD_BUSY;
          end
`endif
          MD_MTHI: hi_d = E_rs;
          MD_MTLO: lo_d = E_rs;
          default: ;
        endcase
      end
    end else begin
      // Starts are ignored while busy, including on the final busy cycle.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_d    = phi_q;
        lo_d    = plo_q;
        state_d = MD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign busy       = (state_q == MD_BUSY);
  assign HI         = hi_q;
  assign LO         = lo_q;
  assign isStall_md = D_isMd && (busy || E_start);

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of div/divu.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port E_start  input  1  E-stage instruction is an MDU op and is valid this cycle.
REQ-006 SHALL have port E_mdop  input  3  op code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port E_rs  input  32  forwarded rs operand.
REQ-008 SHALL have port E_rt  input  32  forwarded rt operand.
REQ-009 SHALL have port D_isMd  input  1  D-stage instruction is any MDU op, including mfhi/mflo.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.
REQ-013 SHALL have port isStall_md  output  1  MDU stall request, ORed into the D-stage stall by the pipeline.

Function
REQ-014 SHALL implement two states: IDLE (counter = 0) and BUSY (counter != 0); busy = (state == BUSY).
REQ-015 SHALL accept E_start only in IDLE; E_start while BUSY SHALL be ignored and SHALL leave state, counter and results unchanged.
REQ-016 On an accepted MULT/MULTU at edge T: SHALL compute the 64-bit product of E_rs and E_rt (signed/unsigned) into pending registers and load the counter with MULT_CYCLES.
REQ-017 On an accepted DIV/DIVU at edge T: SHALL load quotient (pending LO) and remainder (pending HI) and load the counter with DIV_CYCLES.
REQ-018 Signed division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero SHALL give LO = 32'hFFFFFFFF and HI = dividend; signed 0x80000000 / -1 SHALL give LO = 0x80000000 and HI = 0.
REQ-020 busy SHALL be high for exactly N cycles after edge T, where N is the loaded count; the counter SHALL decrement once per cycle.
REQ-021 On the edge where the counter goes 1 -> 0, HI/LO SHALL be updated from the pending registers; new values SHALL be visible in the first cycle with busy low.
REQ-022 MTHI/MTLO accepted in IDLE SHALL write E_rs to HI/LO at the next edge, without entering BUSY.
REQ-023 isStall_md SHALL equal D_isMd && (busy || E_start), and SHALL be purely combinational.
REQ-024 A start arriving in the same cycle as the BUSY -> IDLE transition SHALL be ignored; the resulting stall prevents this case in-pipeline.
REQ-025 HI/LO SHALL be readable (mfhi/mflo) only through the registered outputs; no bypass of pending results.

Reset
REQ-026 reset SHALL force IDLE and clear the counter, HI, LO and pending registers to 0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard the pending result; busy SHALL be low while reset is asserted.

Configuration
REQ-028 Macro MDU_DIV_EN defined: DIV/DIVU SHALL behave per REQ-017..REQ-019.
REQ-029 Macro MDU_DIV_EN undefined: DIV/DIVU SHALL be treated as no-ops (no BUSY, HI/LO unchanged), and no divider logic SHALL be synthesized.

Structure
REQ-030 Op-code localparams for E_mdop and the default cycle counts SHALL live in shared package mdu_pkg, also used by the decoder.
REQ-031 No sub-module SHALL be used; the arithmetic SHALL be coded inline, guarded by MDU_DIV_EN.

Verification
REQ-032 MULT with rs=0xFFFFFFFF, rt=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=0x1, LO=0xFFFFFFFE.
REQ-033 DIV with rs=-7, rt=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV by 0 -> LO=0xFFFFFFFF, HI=rs.
REQ-034 MTHI with rs=0x1234 in IDLE -> HI=0x1234 next cycle, busy never high.
REQ-035 D_isMd=1 during BUSY, and D_isMd=1 with E_start=1 in IDLE -> isStall_md=1 in both cases; D_isMd=0 during BUSY -> isStall_md=0.
REQ-036 Reset pulsed at cycle 3 of a DIV -> busy=0, HI=LO=0 immediately; the old result never appears.
REQ-037 Build without MDU_DIV_EN: DIV issued -> busy stays 0 and HI/LO are unchanged.
